// File: rtl/encoder8to3_event_pkg.sv
// Shared constants and types for the hole-hit event encoder.
// Imported by the encoder top level and its priority-encoder sub-module.
package encoder8to3_event_pkg;

  localparam int NUM_HOLES           = 8;
  localparam int IDX_W               = 3;
  localparam int SYNC_STAGES_DEFAULT = 2;

  localparam bit RR    = 1'b1;
  localparam bit FIXED = 1'b0;

  typedef logic [NUM_HOLES-1:0] hole_vec_t;
  typedef logic [IDX_W-1:0]     hole_idx_t;

  function automatic hole_vec_t idx_to_mask(input hole_idx_t i);
    return hole_vec_t'(1) << i;
  endfunction

endpackage

// File: rtl/encoder8to3_event_rr_priority.sv
// Combinational rotating-priority encoder: searches req_vec starting at
// bit 'start' and wrapping, and reports the first set index.
module rr_priority_encoder8to3
  import encoder8to3_event_pkg::*;
(
  input  logic [NUM_HOLES-1:0] req_vec,
  input  logic [IDX_W-1:0]     start,
  output logic                 found,
  output logic [IDX_W-1:0]     index
);

  hole_vec_t rotated;
  hole_idx_t offset;

  // Rotate so 'start' sits at bit 0, then take the lowest set bit.
  always_comb begin
    rotated = (req_vec >> start) | (req_vec << (NUM_HOLES - int'(start)));
    found   = |req_vec;
    offset  = '0;
    for (int k = NUM_HOLES - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        offset = hole_idx_t'(k);
      end
    end
    index = start + offset;
  end

endmodule

// File: rtl/encoder8to3_event.sv
// Turns eight asynchronous hole-hit lines into one-at-a-time hole indices
// handed to the processor through a valid/ack handshake.
module encoder8to3_event
  import encoder8to3_event_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter bit ROUND_ROBIN = RR
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_HOLES-1:0] req,
  input  logic                 ack,
  input  logic                 clear_overrun,
  output logic [IDX_W-1:0]     idx,
  output logic                 valid,
  output logic [NUM_HOLES-1:0] pending,
  output logic                 overrun
);

  hole_vec_t sync_q [SYNC_STAGES];
  hole_vec_t sync_d;
  hole_vec_t sync_s;
  hole_vec_t rise;

  hole_idx_t ptr;
  hole_idx_t search_start;
  logic      sel_found;
  hole_idx_t sel_idx;

  logic      accept;
  logic      load;
  hole_vec_t accept_mask;
  hole_vec_t pending_nxt;
  logic      overrun_hit;

  // Synchroniser chain plus one history register for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      sync_d <= '0;
    end else begin
      sync_q[0] <= req;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      sync_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_s       = sync_q[SYNC_STAGES-1];
  assign rise         = sync_s & ~sync_d;
  assign search_start = ROUND_ROBIN ? ptr : '0;

  rr_priority_encoder8to3 u_prio (
    .req_vec (pending),
    .start   (search_start),
    .found   (sel_found),
    .index   (sel_idx)
  );

  // A rise on the hole being accepted this edge is a fresh event, not a loss.
  always_comb begin
    accept      = valid & ack;
    load        = ~valid & sel_found;
    accept_mask = accept ? idx_to_mask(idx) : '0;
    pending_nxt = (pending & ~accept_mask) | rise;
    overrun_hit = |(rise & pending & ~accept_mask);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx     <= '0;
      valid   <= 1'b0;
      pending <= '0;
      overrun <= 1'b0;
      ptr     <= '0;
    end else begin
      pending <= pending_nxt;
      if (overrun_hit) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end
      if (accept) begin
        valid <= 1'b0;
        ptr   <= idx + hole_idx_t'(1);
      end else if (load) begin
        valid <= 1'b1;
        idx   <= sel_idx;
      end
    end
  end

endmodule
